// File: rtl/idli_sqi_ctrl_m_pkg.sv
// rtl/idli_sqi_ctrl_m_pkg.sv - shared SQI types: instruction codes, controller states, nibble slice
package idli_sqi_ctrl_m_pkg;

  typedef logic [3:0] slice_t;

  typedef enum logic [7:0] {
    SQI_WRITE = 8'h02,
    SQI_READ  = 8'h03
  } sqi_instr_t;

  typedef enum logic [2:0] {
    GAP,
    IDLE,
    INSTR,
    ADDR,
    DUMMY,
    DATA
  } sqi_ctrl_state_t;

  localparam logic [7:0] INSTR_LAST = 8'd1;
  localparam logic [7:0] ADDR_LAST  = 8'd3;
  localparam logic [7:0] DUMMY_LAST = 8'd1;

endpackage

// File: rtl/idli_sqi_ctrl_m_if.sv
// rtl/idli_sqi_ctrl_m_if.sv - core-side single-word request/response port of the SQI controller
interface idli_sqi_ctrl_m_if #(parameter int DATA_BYTES = 2);
  import idli_sqi_ctrl_m_pkg::*;

  localparam int DW = 8 * DATA_BYTES;

  logic          req_vld;
  logic          req_rdy;
  logic          req_wr;
  logic [15:0]   req_addr;
  logic [DW-1:0] req_data;
  logic          rd_vld;
  logic [DW-1:0] rd_data;

  modport master (
    output req_vld, req_wr, req_addr, req_data,
    input  req_rdy, rd_vld, rd_data
  );

  modport slave (
    input  req_vld, req_wr, req_addr, req_data,
    output req_rdy, rd_vld, rd_data
  );
endinterface

// File: rtl/idli_sqi_ctrl_m.sv
// rtl/idli_sqi_ctrl_m.sv - quad-SIO initiator turning single-word core requests into SCK/CS/SIO frames
module idli_sqi_ctrl_m
  import idli_sqi_ctrl_m_pkg::*;
#(
  parameter int DATA_BYTES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  idli_sqi_ctrl_m_if.slave        bus,
  output logic                    sqi_sck,
  output logic                    sqi_cs,
  output slice_t                  sqi_sio,
  output logic                    sqi_sio_en,
  input  slice_t                  sqi_sio_in
);

  localparam int DW = 8 * DATA_BYTES;
  localparam int SW = 24 + DW;
  localparam logic [7:0] DATA_LAST = 8'(2 * DATA_BYTES - 1);

  sqi_ctrl_state_t state;
  sqi_instr_t      instr;
  logic            hi;
  logic            wr;
  logic [SW-1:0]   shreg;
  logic [7:0]      cnt;

  assign instr       = bus.req_wr ? SQI_WRITE : SQI_READ;
  assign sqi_sck     = hi;
  assign bus.req_rdy = (state == IDLE) && hi;

  // All state moves happen on the edge that ends a HI phase, so SIO changes while SCK falls
  // and reads sample the nibble the memory has held through the whole HI phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= GAP;
      hi          <= 1'b0;
      wr          <= 1'b0;
      shreg       <= '0;
      cnt         <= '0;
      sqi_cs      <= 1'b1;
      sqi_sio     <= '0;
      sqi_sio_en  <= 1'b0;
      bus.rd_vld  <= 1'b0;
      bus.rd_data <= '0;
    end else begin
      hi         <= ~hi;
      bus.rd_vld <= 1'b0;
      if (hi) begin
        if (state inside {INSTR, ADDR, DUMMY, DATA}) begin
          sqi_sio <= shreg[SW-1 -: 4];
          shreg   <= {shreg[SW-5:0], sqi_sio_in};
          cnt     <= cnt - 8'd1;
        end
        case (state)
          GAP: state <= IDLE;
          IDLE: begin
            if (bus.req_vld) begin
              state      <= INSTR;
              wr         <= bus.req_wr;
              shreg      <= {instr[3:0], bus.req_addr, bus.req_data, 4'h0};
              sqi_sio    <= instr[7:4];
              sqi_cs     <= 1'b0;
              sqi_sio_en <= 1'b1;
              cnt        <= INSTR_LAST;
            end
          end
          INSTR: begin
            if (cnt == 8'd0) begin
              state <= ADDR;
              cnt   <= ADDR_LAST;
            end
          end
          ADDR: begin
            if (cnt == 8'd0) begin
              if (wr) begin
                state <= DATA;
                cnt   <= DATA_LAST;
              end else begin
                state      <= DUMMY;
                cnt        <= DUMMY_LAST;
                sqi_sio_en <= 1'b0;
              end
            end
          end
          DUMMY: begin
            if (cnt == 8'd0) begin
              state <= DATA;
              cnt   <= DATA_LAST;
            end
          end
          DATA: begin
            if (cnt == 8'd0) begin
              state      <= GAP;
              sqi_cs     <= 1'b1;
              sqi_sio_en <= 1'b0;
              sqi_sio    <= '0;
              if (!wr) begin
                bus.rd_vld  <= 1'b1;
                bus.rd_data <= {shreg[DW-5:0], sqi_sio_in};
              end
            end
          end
          default: state <= GAP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// tb/tb_idli_sqi_ctrl_m.sv - directed bench for idli_sqi_ctrl_m with a behavioural quad-SIO memory
module tb_idli_sqi_ctrl_m;
  import idli_sqi_ctrl_m_pkg::*;

  logic   clk;
  logic   rst_n;
  logic   sck;
  logic   cs;
  slice_t sio;
  logic   sio_en;
  slice_t sio_bus;
  slice_t mem_sio;

  idli_sqi_ctrl_m_if #(.DATA_BYTES(2)) bus ();

  idli_sqi_ctrl_m #(.DATA_BYTES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .sqi_sck    (sck),
    .sqi_cs     (cs),
    .sqi_sio    (sio),
    .sqi_sio_en (sio_en),
    .sqi_sio_in (sio_bus)
  );

  assign sio_bus = sio_en ? sio : mem_sio;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: READ 0x03 / WRITE 0x02, 16-bit address, 2 dummy nibbles on read
  logic [7:0]  mem [0:65535];
  int          mcnt = 0;
  logic [7:0]  minstr = 8'h00;
  logic [15:0] maddr = 16'h0000;
  logic [3:0]  mhi = 4'h0;
  logic [4:0]  nib_q [$];

  initial mem_sio = 4'h0;

  always @(posedge sck) begin
    int j;
    logic [7:0] b;
    if (cs) begin
      mcnt = 0;
    end else begin
      nib_q.push_back({sio_en, sio_bus});
      if (mcnt < 2) minstr = {minstr[3:0], sio_bus};
      else if (mcnt < 6) maddr = {maddr[11:0], sio_bus};
      else if (minstr == 8'h02) begin
        j = mcnt - 6;
        if (j % 2 == 0) mhi = sio_bus;
        else mem[maddr + 16'(j / 2)] = {mhi, sio_bus};
      end
      mcnt++;
    end
    mem_sio = 4'h0;
    if (!cs && minstr == 8'h03 && mcnt >= 9 && mcnt <= 12) begin
      j = mcnt - 9;
      b = mem[maddr + 16'(j / 2)];
      mem_sio = (j % 2 == 0) ? b[7:4] : b[3:0];
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; drives the request and returns just after the accepting edge.
  task automatic do_accept(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                           input logic hold, output int gap);
    logic ok;
    ok  = 1'b0;
    gap = 0;
    bus.req_vld  = 1'b1;
    bus.req_wr   = wr;
    bus.req_addr = addr;
    bus.req_data = data;
    nib_q.delete();
    for (int k = 0; k < 40; k++) begin
      if (cs) gap++;
      if (bus.req_rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accept", ok, 1'b1);
    if (ok) @(posedge clk);
    #1 bus.req_vld = hold;
  endtask

  task automatic wait_done(output int cs_low, output int vld_edge, output int vld_n,
                           output logic [15:0] rd);
    logic done;
    done = 1'b0;
    cs_low = 0;
    vld_edge = -1;
    vld_n = 0;
    rd = 16'h0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!cs) cs_low++;
      if (bus.rd_vld) begin
        vld_n++;
        vld_edge = k - 1;
        rd = bus.rd_data;
      end
      if (cs) begin
        done = 1'b1;
        break;
      end
    end
    chk("xfer_done", done, 1'b1);
  endtask

  function automatic logic [63:0] pack_nibs(input int first, input int n);
    logic [63:0] p;
    p = '0;
    for (int i = first; i < first + n && i < nib_q.size(); i++) p = {p[59:0], nib_q[i][3:0]};
    return p;
  endfunction

  function automatic int count_en(input int first, input int n);
    int c;
    c = 0;
    for (int i = first; i < first + n && i < nib_q.size(); i++) c += int'(nib_q[i][4]);
    return c;
  endfunction

  initial begin
    int gap, cs_low, vld_edge, vld_n, bad_cs, bad_en, sck_err, rdy_err, vld_seen;
    logic [15:0] rd;
    logic prev_sck, prev_rdy;

    rst_n = 1'b0;
    bus.req_vld = 1'b0;
    bus.req_wr = 1'b0;
    bus.req_addr = 16'h0;
    bus.req_data = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_sck", sck, 1'b0);
    chk("rst_cs", cs, 1'b1);
    chk("rst_sio", sio, 4'h0);
    chk("rst_sio_en", sio_en, 1'b0);
    chk("rst_rdy", bus.req_rdy, 1'b0);
    chk("rst_rd_vld", bus.rd_vld, 1'b0);
    chk("rst_rd_data", bus.rd_data, 16'h0);
    rst_n = 1'b1;

    // write 0x1234 to 0x0010
    do_accept(1'b1, 16'h0010, 16'h1234, 1'b0, gap);
    wait_done(cs_low, vld_edge, vld_n, rd);
    chk("wr_cs_low", cs_low, 20);
    chk("wr_no_vld", vld_n, 0);
    chk("wr_nib_cnt", nib_q.size(), 10);
    chk("wr_nibs", pack_nibs(0, 10), 64'h02_0010_1234);
    chk("wr_sio_en", count_en(0, 10), 10);
    chk("wr_mem10", mem[16'h0010], 8'h12);
    chk("wr_mem11", mem[16'h0011], 8'h34);

    // read it back
    do_accept(1'b0, 16'h0010, 16'h0000, 1'b0, gap);
    wait_done(cs_low, vld_edge, vld_n, rd);
    chk("rd_cs_low", cs_low, 24);
    chk("rd_nib_cnt", nib_q.size(), 12);
    chk("rd_nibs", pack_nibs(0, 6), 64'h03_0010);
    chk("rd_hdr_en", count_en(0, 6), 6);
    chk("rd_dummy_en", count_en(6, 6), 0);
    chk("rd_vld_n", vld_n, 1);
    chk("rd_vld_lat", vld_edge, 24);
    chk("rd_data", rd, 16'h1234);
    @(negedge clk);
    chk("rd_data_held", bus.rd_data, 16'h1234);

    // back-to-back: valid held through write 0xBEEF@0x0100 and the following read
    do_accept(1'b1, 16'h0100, 16'hBEEF, 1'b1, gap);
    bus.req_wr = 1'b0;
    bus.req_addr = 16'h0100;
    wait_done(cs_low, vld_edge, vld_n, rd);
    chk("b2b_wr_cs_low", cs_low, 20);
    do_accept(1'b0, 16'h0100, 16'h0000, 1'b0, gap);
    chk("b2b_gap_ge2", gap >= 2, 1'b1);
    wait_done(cs_low, vld_edge, vld_n, rd);
    chk("b2b_rd_vld_n", vld_n, 1);
    chk("b2b_rd_data", rd, 16'hBEEF);

    // address wrap
    do_accept(1'b1, 16'hFFFF, 16'hA55A, 1'b0, gap);
    wait_done(cs_low, vld_edge, vld_n, rd);
    chk("wrap_memffff", mem[16'hFFFF], 8'hA5);
    chk("wrap_mem0000", mem[16'h0000], 8'h5A);
    do_accept(1'b0, 16'hFFFF, 16'h0000, 1'b0, gap);
    wait_done(cs_low, vld_edge, vld_n, rd);
    chk("wrap_rd_data", rd, 16'hA55A);

    // reset during the third address nibble of a read
    do_accept(1'b0, 16'h0010, 16'h0000, 1'b0, gap);
    vld_seen = 0;
    repeat (9) begin
      @(negedge clk);
      vld_seen += int'(bus.rd_vld);
    end
    rst_n = 1'b0;
    #1;
    chk("abort_cs", cs, 1'b1);
    chk("abort_sio_en", sio_en, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_rdy0", bus.req_rdy, 1'b0);
    vld_seen += int'(bus.rd_vld);
    @(negedge clk);
    chk("abort_rdy1", bus.req_rdy, 1'b0);
    vld_seen += int'(bus.rd_vld);
    chk("abort_no_vld", vld_seen, 0);
    do_accept(1'b0, 16'h0010, 16'h0000, 1'b0, gap);
    wait_done(cs_low, vld_edge, vld_n, rd);
    chk("abort_rd_vld_n", vld_n, 1);
    chk("abort_rd_data", rd, 16'h1234);

    // idle with no request
    bus.req_vld = 1'b0;
    repeat (3) @(negedge clk);
    nib_q.delete();
    bad_cs = 0;
    bad_en = 0;
    sck_err = 0;
    rdy_err = 0;
    prev_sck = sck;
    prev_rdy = bus.req_rdy;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!cs) bad_cs++;
      if (sio_en) bad_en++;
      if (sck == prev_sck) sck_err++;
      if (bus.req_rdy == prev_rdy) rdy_err++;
      prev_sck = sck;
      prev_rdy = bus.req_rdy;
    end
    chk("idle_cs", bad_cs, 0);
    chk("idle_sio_en", bad_en, 0);
    chk("idle_sck_toggle", sck_err, 0);
    chk("idle_rdy_alt", rdy_err, 0);
    chk("idle_no_nibs", nib_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
